// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, addresses the async
// instruction ROM, and queues {pc, inst, err} entries in a 2-deep prefetch
// buffer that feeds decode over valid/ready. Redirects flush and restart;
// a misaligned or out-of-range PC produces one fault entry, then fetch halts.
module inst_fetch_ctrl #(
    parameter int          ADDR_W    = 8,
    parameter int          ROM_DEPTH = 110,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic              out_err,
    output logic              halted
);

    localparam logic [29:0] ROM_DEPTH_W = 30'(ROM_DEPTH);

    // Control state (reset)
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        halted_q, halted_d;

    // Buffer payload (not reset; masked at the outputs while empty)
    logic [31:0] pc_q   [2];
    logic [31:0] inst_q [2];
    logic        err_q  [2];

    logic        pop;
    logic        push;
    logic        fetch_err;
    logic [31:0] push_inst;

    assign rom_addr  = fetch_pc_q[ADDR_W+1:2];

    assign out_valid = (count_q != 2'd0);
    assign out_pc    = out_valid ? pc_q[rd_ptr_q]   : 32'h0;
    assign out_inst  = out_valid ? inst_q[rd_ptr_q] : 32'h0;
    assign out_err   = out_valid ? err_q[rd_ptr_q]  : 1'b0;
    assign halted    = halted_q;

    // A fault entry carries a zero instruction so decode never sees stale ROM data
    assign fetch_err = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q[31:2] >= ROM_DEPTH_W);
    assign push_inst = fetch_err ? 32'h0 : rom_inst;

    // Handshake: a pop frees a slot in the same cycle, so a full buffer can still push
    always_comb begin
        pop  = out_valid && out_ready;
        push = !redirect_valid && !halted_q && ((count_q != 2'd2) || pop);
    end

    // Next-state: redirect flushes everything and overrides push/pop
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        halted_d   = halted_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            count_d    = 2'd0;
            halted_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
                if (fetch_err) begin
                    halted_d = 1'b1;
                end else begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            halted_q   <= halted_d;
        end
    end

    // Buffer write port; push already excludes redirect, and reset masks via count
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr_q]   <= fetch_pc_q;
            inst_q[wr_ptr_q] <= push_inst;
            err_q[wr_ptr_q]  <= fetch_err;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;
    logic        halted;

    logic [31:0] rom [256];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_inst = rom[rom_addr];

    inst_fetch_ctrl #(.ADDR_W(8), .ROM_DEPTH(110), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_err        (out_err),
        .halted         (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst, input logic err);
        chk({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        chk({tag, ".pc"},    out_pc, pc);
        chk({tag, ".inst"},  out_inst, inst);
        chk({tag, ".err"},   {31'h0, out_err}, {31'h0, err});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'hAC, 8'(i + 1), 16'(i * 4)};
        end
        rom[13]  = 32'h2401_0001;
        rom[14]  = 32'h0001_1100;
        rom[108] = 32'h8C0D_0078;
        rom[109] = 32'h0800_000D;

        // Reset held 3 cycles
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        step(); step(); step();
        chk("rst.valid",  {31'h0, out_valid}, 32'h0);
        chk("rst.pc",     out_pc, 32'h0);
        chk("rst.inst",   out_inst, 32'h0);
        chk("rst.err",    {31'h0, out_err}, 32'h0);
        chk("rst.halted", {31'h0, halted}, 32'h0);
        chk("rst.addr",   {24'h0, rom_addr}, 32'h0);

        // Release: one entry per cycle
        reset = 1'b0;
        step(); chk_head("run0", 32'h00, 32'hAC01_0000, 1'b0);
        step(); chk_head("run1", 32'h04, 32'hAC02_0004, 1'b0);
        step(); chk_head("run2", 32'h08, 32'hAC03_0008, 1'b0);

        // Backpressure from reset
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("bp.addr", {24'h0, rom_addr}, 32'h2);
        chk_head("bp.hold", 32'h00, 32'hAC01_0000, 1'b0);
        out_ready = 1'b1;
        step(); chk_head("bp1", 32'h04, 32'hAC02_0004, 1'b0);
        step(); chk_head("bp2", 32'h08, 32'hAC03_0008, 1'b0);
        step(); chk_head("bp3", 32'h0C, 32'hAC04_000C, 1'b0);

        // Fill, then redirect to 0x34
        out_ready = 1'b0;
        step(); step();
        chk_head("full", 32'h0C, 32'hAC04_000C, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h34;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        chk("rd34.flush", {31'h0, out_valid}, 32'h0);
        step(); chk_head("rd34a", 32'h34, 32'h2401_0001, 1'b0);
        step(); chk_head("rd34b", 32'h38, 32'h0001_1100, 1'b0);

        // Redirect near the end of ROM: runs off into a fault
        redirect_valid = 1'b1; redirect_pc = 32'h1B0;
        step();
        redirect_valid = 1'b0;
        chk("rd1b0.flush", {31'h0, out_valid}, 32'h0);
        step(); chk_head("rd1b0a", 32'h1B0, 32'h8C0D_0078, 1'b0);
        step(); chk_head("rd1b0b", 32'h1B4, 32'h0800_000D, 1'b0);
        step(); chk_head("oor", 32'h1B8, 32'h0, 1'b1);
        chk("oor.halted", {31'h0, halted}, 32'h1);
        step();
        chk("oor.drained", {31'h0, out_valid}, 32'h0);
        step();
        chk("oor.still", {31'h0, out_valid}, 32'h0);
        chk("oor.halt2", {31'h0, halted}, 32'h1);
        chk("oor.addr", {24'h0, rom_addr}, 32'h6E);

        // Redirect clears halted
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("clr.halted", {31'h0, halted}, 32'h0);
        chk("clr.flush", {31'h0, out_valid}, 32'h0);
        step(); chk_head("clr0", 32'h00, 32'hAC01_0000, 1'b0);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h36;
        step();
        redirect_valid = 1'b0;
        step(); chk_head("mis", 32'h36, 32'h0, 1'b1);
        chk("mis.halted", {31'h0, halted}, 32'h1);
        step();
        chk("mis.drained", {31'h0, out_valid}, 32'h0);

        // Reset beats a simultaneous redirect and pop
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        step(); chk_head("pre", 32'h10, 32'hAC05_0010, 1'b0);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        reset = 1'b0; redirect_valid = 1'b0;
        chk("rr.valid",  {31'h0, out_valid}, 32'h0);
        chk("rr.addr",   {24'h0, rom_addr}, 32'h0);
        chk("rr.halted", {31'h0, halted}, 32'h0);
        step(); chk_head("rr0", 32'h00, 32'hAC01_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Instruction-fetch controller that sequences the asynchronous instruction ROM for the CPU front end. It owns the fetch PC and drives the ROM word address. Each fetched {pc, inst} pair goes into a 2-entry prefetch buffer, which feeds the decode stage over a valid/ready handshake. Branch, jump and exception redirects flush the buffer and restart fetch. Out-of-range and misaligned PCs are flagged and fetch halts.

Parameters:
ADDR_W, 8, ROM word-address width; rom_addr = fetch_pc[ADDR_W+1:2]
ROM_DEPTH, 110, number of populated ROM words; word index >= ROM_DEPTH is out of range
RESET_PC, 32'h0000_0000, fetch PC loaded by reset

Ports:
clk  in  1  single clock, all state on posedge
reset  in  1  synchronous, active-high reset
rom_addr  out  ADDR_W  word address to instruction ROM, combinational from fetch_pc
rom_inst  in  32  ROM data, valid in the same cycle as rom_addr
redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  32  new byte PC
out_valid  out  1  buffer head valid
out_ready  in  1  decode accepts head
out_pc  out  32  byte PC of head entry
out_inst  out  32  instruction of head entry
out_err  out  1  head entry is a fetch fault (misaligned or out of range)
halted  out  1  fetch stopped after a fault, awaiting redirect

Behaviour:
- Reset (sync, active-high):
  - fetch_pc <= RESET_PC; buffer emptied; halted <= 0.
  - Outputs go to out_valid=0, out_pc=0, out_inst=0, out_err=0.
  - Reset takes priority over all other inputs, including mid-redirect or mid-stall.
- State: fetch_pc (32b); 2-entry FIFO of {pc[31:0], inst[31:0], err}; rd/wr pointers (1b) plus count (0..2); halted flag.
- Outputs: out_* are driven straight from the FIFO head entry. out_valid = (count != 0).
- pop = out_valid & out_ready.
- push condition: !redirect_valid & !halted & (count < 2 | pop). Pushing into a full FIFO in the same cycle as a pop is allowed.
- On push:
  - Entry = {fetch_pc, inst, err}.
  - err = (fetch_pc[1:0] != 0) | (fetch_pc[31:2] >= ROM_DEPTH).
  - inst = err ? 32'h0 : rom_inst.
  - If err: halted <= 1 and fetch_pc is held. Otherwise fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
- Redirect (redirect_valid=1) has priority over push and pop:
  - FIFO count <= 0 and any pending pop is discarded.
  - fetch_pc <= redirect_pc; halted <= 0; no push that cycle.
  - out_valid=0 in the cycle after the redirect. The first redirected entry is valid 2 cycles after the redirect pulse.
- Latency: the first cycle with reset=0 pushes RESET_PC, so out_valid=1 on the next cycle. In steady state with out_ready=1 held, throughput is 1 instruction per cycle.
- Backpressure: with out_ready=0 the FIFO fills to 2 and fetch_pc stops advancing. rom_addr then stays constant. No entry is dropped or duplicated.
- Halted: once the fault entry is pushed, no further pushes occur. Remaining entries drain normally; the fault entry is presented with out_err=1. Only a redirect or reset clears halted.
- rom_addr is driven even while halted or the FIFO is full; the ROM is side-effect free.
- Simultaneous pop and redirect: the redirect wins and the popped entry counts as flushed. Decode must ignore it because redirect semantics kill it.

Test Plan:
- Reset held 3 cycles, then released with out_ready=1 -> out_valid first high 1 cycle after release. Expect out_pc 0x00 inst AC010000, then 0x04 AC020004, then 0x08 AC030008 on consecutive cycles.
- out_ready=0 for 6 cycles after reset -> count saturates at 2 (pcs 0x00, 0x04) and rom_addr stays at 2. Release -> pcs 0x00, 0x04, 0x08, 0x0C in order with no gaps or duplicates.
- FIFO full, redirect_valid with redirect_pc=0x34 -> out_valid=0 next cycle. Then out_pc=0x34 inst 24010001, then 0x38 inst 00011100.
- Redirect to 0x1B0 -> entries 0x1B0 8C0D0078 and 0x1B4 0800000D, then 0x1B8 with out_err=1 inst 0. halted=1 and no further out_valid. Redirect to 0x00 clears halted and fetch resumes at AC010000.
- Redirect to misaligned 0x36 -> single entry pc 0x36 out_err=1 inst 0; halted=1.
- Redirect asserted in the same cycle as pop and reset -> reset wins: fetch_pc=0, buffer empty, first entry pc 0x00.
